// File: rtl/itof.sv
// ---------------------------------------------------------------------------
// itof -- pipelined signed 32-bit integer to IEEE-754 single conversion.
//
// Three register stages, one conversion accepted every clock, no handshake.
// An operand sampled on edge E0 produces its result on y after edge E2.
//
//   stage 1 : sign capture and two's-complement magnitude
//   stage 2 : leading-zero count, left normalisation, zero detect
//   stage 3 : exponent, round-to-nearest-even, pack into y
//
// Ports
//   x1  : in  32  signed two's-complement operand
//   y   : out 32  single-precision result {sign, exp[7:0], mant[22:0]}
//   clk : in   1  clock, rising edge
//   rst : in   1  asynchronous active-high reset, clears every stage
// ---------------------------------------------------------------------------
module itof (
   input  logic [31:0] x1,
   output logic [31:0] y,
   input  logic        clk,
   input  logic        rst
);

   // ---------------- stage 1 ----------------
   logic [31:0] mag_next;
   logic        s1_sign_reg;
   logic [31:0] s1_mag_reg;

   // 0x80000000 negates to itself, which read as unsigned is exactly 2^31.
   assign mag_next = x1[31] ? (~x1 + 32'd1) : x1;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_sign_reg <= 1'b0;
         s1_mag_reg  <= 32'd0;
      end else begin
         s1_sign_reg <= x1[31];
         s1_mag_reg  <= mag_next;
      end
   end

   // ---------------- stage 2 ----------------
   logic [5:0]  lzc_next;
   logic [31:0] norm_next;
   logic        zero_next;
   logic        s2_sign_reg;
   logic [31:0] s2_norm_reg;
   logic [5:0]  s2_lzc_reg;
   logic        s2_zero_reg;

   // Ascending scan: the highest set bit is the last one to write lzc_next.
   always_comb begin
      lzc_next = 6'd32;
      for (int i = 0; i < 32; i++) begin
         if (s1_mag_reg[i]) begin
            lzc_next = 6'(31 - i);
         end
      end
   end

   assign norm_next = s1_mag_reg << lzc_next;
   assign zero_next = (s1_mag_reg == 32'd0);

   // The zero flag resets to 1 so the drained pipeline packs to +0 rather
   // than to a spurious exponent built from cleared registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s2_sign_reg <= 1'b0;
         s2_norm_reg <= 32'd0;
         s2_lzc_reg  <= 6'd0;
         s2_zero_reg <= 1'b1;
      end else begin
         s2_sign_reg <= s1_sign_reg;
         s2_norm_reg <= norm_next;
         s2_lzc_reg  <= lzc_next;
         s2_zero_reg <= zero_next;
      end
   end

   // ---------------- stage 3 ----------------
   logic [22:0] mant_trunc;
   logic        guard_bit;
   logic        sticky_bit;
   logic        lsb_bit;
   logic        round_up;
   logic [23:0] mant_rnd;
   logic [7:0]  exp_base;
   logic [7:0]  exp_next;
   logic [31:0] y_next;
   logic [31:0] y_reg;

   assign mant_trunc = s2_norm_reg[30:8];
   assign guard_bit  = s2_norm_reg[7];
   assign sticky_bit = |s2_norm_reg[6:0];
   assign lsb_bit    = s2_norm_reg[8];
   assign round_up   = guard_bit & (sticky_bit | lsb_bit);

   // Bit 23 of the rounded mantissa is the carry-out; when set the fraction
   // bits are already all zero and only the exponent needs bumping.
   assign mant_rnd = {1'b0, mant_trunc} + 24'(round_up);
   assign exp_base = 8'd158 - {2'b00, s2_lzc_reg};
   assign exp_next = exp_base + 8'(mant_rnd[23]);

   always_comb begin
      y_next = 32'd0;
      if (!s2_zero_reg) begin
         y_next = {s2_sign_reg, exp_next, mant_rnd[22:0]};
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         y_reg <= 32'd0;
      end else begin
         y_reg <= y_next;
      end
   end

   assign y = y_reg;

endmodule

// File: tb/tb_itof.sv
// ---------------------------------------------------------------------------
// tb_itof -- scoreboard bench for itof.
// Stimulus drives x1 on falling edges and queues the expected float from an
// arithmetic reference model; a monitor pops one entry per rising edge once
// three entries are queued (the depth of the pipeline) and compares y.
// ---------------------------------------------------------------------------
module tb_itof;

   logic        clk;
   logic        rst;
   logic [31:0] x1;
   logic [31:0] y;

   typedef struct {
      bit          chk;
      logic [31:0] x;
      logic [31:0] exp;
   } sb_entry_t;

   sb_entry_t sb_q[$];
   int        n_checks;
   int        n_fail;

   itof dut (
      .x1  (x1),
      .y   (y),
      .clk (clk),
      .rst (rst)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: exact integer arithmetic, round by comparing the discarded
   // remainder against one half unit in the last place.
   function automatic logic [31:0] ref_itof(input logic [31:0] xv);
      longint v;
      longint m;
      longint q;
      longint rem;
      longint half;
      int     e;
      logic   s;
      v = longint'(signed'(xv));
      if (v == 0) return 32'd0;
      s = (v < 0);
      m = s ? -v : v;
      e = 0;
      while ((m >> (e + 1)) != 0) e++;
      if (e <= 23) begin
         q = m << (23 - e);
      end else begin
         q    = m >> (e - 23);
         rem  = m - (q << (e - 23));
         half = 64'sd1 << (e - 24);
         if (rem > half || (rem == half && q[0])) q = q + 1;
         if (q == (64'sd1 << 24)) begin
            q = q >> 1;
            e = e + 1;
         end
      end
      return {s, 8'(e + 127), q[22:0]};
   endfunction

   task automatic drive(input logic [31:0] xv, input bit chk);
      @(negedge clk);
      x1 = xv;
      sb_q.push_back('{chk, xv, ref_itof(xv)});
   endtask

   task automatic check_now(input string name, input logic [31:0] req);
      n_checks++;
      if (y !== req) begin
         n_fail++;
         $display("FAIL %s y=%h required=%h", name, y, req);
      end else begin
         $display("ok   %s y=%h", name, y);
      end
   endtask

   // Monitor: the output after edge Ek belongs to the entry sampled at Ek-2.
   initial begin
      sb_entry_t e;
      forever begin
         @(posedge clk);
         #2;
         if (sb_q.size() >= 3) begin
            e = sb_q.pop_front();
            if (e.chk) begin
               n_checks++;
               if (y !== e.exp) begin
                  n_fail++;
                  $display("FAIL stream x1=%h y=%h required=%h", e.x, y, e.exp);
               end else begin
                  $display("ok   stream x1=%h y=%h", e.x, y);
               end
            end
         end
      end
   end

   initial begin
      #200000;
      n_fail++;
      $display("FAIL watchdog simulation time limit reached");
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $fatal(1);
   end

   logic [31:0] directed [11];
   logic [31:0] rv;

   initial begin
      n_checks = 0;
      n_fail   = 0;
      rst      = 1'b1;
      x1       = 32'h1234_5678;
      directed[0]  = 32'd1;
      directed[1]  = 32'hFFFF_FFFF;
      directed[2]  = 32'd0;
      directed[3]  = 32'h7FFF_FFFF;
      directed[4]  = 32'h8000_0000;
      directed[5]  = 32'd16777217;
      directed[6]  = 32'd16777219;
      directed[7]  = 32'd16777221;
      directed[8]  = 32'd33554435;
      directed[9]  = 32'd12345;
      directed[10] = -32'sd12345;

      repeat (3) @(posedge clk);
      #2;
      check_now("reset_state", 32'd0);
      @(negedge clk);
      rst = 1'b0;

      // Directed values, back to back.
      for (int i = 0; i < 11; i++) drive(directed[i], 1'b1);

      // Random streaming.
      for (int i = 0; i < 60; i++) begin
         case ($urandom_range(3))
            0: rv = $urandom;
            1: rv = $urandom_range(32'h00FF_FFFF);
            2: rv = -$urandom_range(32'h00FF_FFFF);
            default: rv = (32'd1 << $urandom_range(30, 24)) + $urandom_range(15);
         endcase
         drive(rv, 1'b1);
      end

      // Mid-stream reset with results in flight.
      drive(32'd100, 1'b1);
      drive(32'd200, 1'b1);
      drive(32'd300, 1'b1);
      @(posedge clk);
      #3;
      rst = 1'b1;
      sb_q.delete();
      #1;
      check_now("reset_async", 32'd0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         x1 = $urandom;
         sb_q.push_back('{1'b1, x1, 32'd0});
      end
      @(negedge clk);
      rst = 1'b0;
      x1  = 32'd2;
      sb_q.push_back('{1'b1, 32'd2, ref_itof(32'd2)});
      for (int i = 0; i < 4; i++) drive($urandom, 1'b1);

      // Flush: filler entries let the last real results reach the monitor.
      for (int i = 0; i < 3; i++) drive(32'd0, 1'b0);
      repeat (3) @(posedge clk);
      #4;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
